cpu_ctrl_fsm: RTL and testbench

- Multicycle control unit that issues every register-file access: drives the RF write enable, write/read addresses, flag-update strobe and data-source selects.
- Also sequences instruction fetch and data memory.
- Holds the instruction register internally and decodes a 16-bit CR16-style subset: opcode[15:12], Rdest[11:8], ext[7:4], Rsrc/imm[3:0]/imm[7:0].
- Sits between unified memory and the datapath (RF, ALU, PC).

---
 rtl/cpu_ctrl_pkg.sv | 100 ++++++++++
 rtl/cpu_instr_decode.sv | 54 +++++
 rtl/cpu_ctrl_fsm.sv | 143 ++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multicycle CPU control unit.
package cpu_ctrl_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned REG_BITS   = 4;
  localparam int unsigned PC_WIDTH   = 16;
  localparam int unsigned ALU_OP_W   = 3;
  localparam int unsigned FIELD_W    = 4;
  localparam int unsigned IMM_W      = 8;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM_RD, LOAD_WB, MEM_WR, ILLEGAL
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_ILLEGAL
  } instr_class_t;

  // Opcode / ext field values
  localparam logic [FIELD_W-1:0] OPC_RTYPE = 4'b0000;
  localparam logic [FIELD_W-1:0] OPC_MEM   = 4'b0100;
  localparam logic [FIELD_W-1:0] CODE_ADD  = 4'b0101;
  localparam logic [FIELD_W-1:0] CODE_SUB  = 4'b1001;
  localparam logic [FIELD_W-1:0] CODE_CMP  = 4'b1011;
  localparam logic [FIELD_W-1:0] CODE_AND  = 4'b0001;
  localparam logic [FIELD_W-1:0] CODE_OR   = 4'b0010;
  localparam logic [FIELD_W-1:0] CODE_XOR  = 4'b0011;
  localparam logic [FIELD_W-1:0] CODE_MOV  = 4'b1101;
  localparam logic [FIELD_W-1:0] EXT_LOAD  = 4'b0000;
  localparam logic [FIELD_W-1:0] EXT_STOR  = 4'b0100;

  // ALU operation encodings
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'd4;
  localparam logic [ALU_OP_W-1:0] ALU_MOV = 3'd5;

  // Data-source select encodings
  localparam logic MEM_ADDR_PC = 1'b0;
  localparam logic MEM_ADDR_RF = 1'b1;
  localparam logic ALU_B_RF    = 1'b0;
  localparam logic ALU_B_IMM   = 1'b1;
  localparam logic WB_ALU      = 1'b0;
  localparam logic WB_MEM      = 1'b1;

  typedef struct packed {
    logic                ok;
    logic [ALU_OP_W-1:0] op;
    logic                wr;
    logic                flags;
    logic                zext;
  } alu_info_t;

  typedef struct packed {
    instr_class_t          cls;
    logic [ALU_OP_W-1:0]   alu_op;
    logic                  alu_b_sel;
    logic [DATA_WIDTH-1:0] imm;
    logic                  wr;
    logic                  flags;
    logic                  legal;
  } decode_t;

  typedef struct packed {
    logic                  pc_en;
    logic                  mem_addr_sel;
    logic                  mem_wr_en;
    logic                  rf_wr_en;
    logic                  flags_en;
    logic [REG_BITS-1:0]   rf_addr1;
    logic [REG_BITS-1:0]   rf_addr2;
    logic [ALU_OP_W-1:0]   alu_op;
    logic                  alu_b_sel;
    logic [DATA_WIDTH-1:0] imm_out;
    logic                  wb_sel;
    logic                  illegal;
  } ctrl_out_t;

  // Map an ALU code (R-type ext or I-type opcode) to its operation attributes
  function automatic alu_info_t alu_lookup(input logic [FIELD_W-1:0] code);
    alu_info_t info;
    info    = '0;
    info.ok = 1'b1;
    info.wr = 1'b1;
    case (code)
      CODE_ADD: begin info.op = ALU_ADD; info.flags = 1'b1; end
      CODE_SUB: begin info.op = ALU_SUB; info.flags = 1'b1; end
      CODE_CMP: begin info.op = ALU_SUB; info.flags = 1'b1; info.wr = 1'b0; end
      CODE_AND: begin info.op = ALU_AND; info.zext = 1'b1; end
      CODE_OR:  begin info.op = ALU_OR;  info.zext = 1'b1; end
      CODE_XOR: begin info.op = ALU_XOR; info.zext = 1'b1; end
      CODE_MOV: begin info.op = ALU_MOV; end
      default:  info = '0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/cpu_instr_decode.sv
// Combinational decode of the instruction register into class and ALU controls.
module cpu_instr_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] ir,
  output decode_t               dec
);

  logic [FIELD_W-1:0] opc;
  logic [FIELD_W-1:0] ext;
  logic [IMM_W-1:0]   imm8;
  logic [FIELD_W-1:0] unused_rdest;
  alu_info_t          r_info;
  alu_info_t          i_info;

  assign opc          = ir[15:12];
  assign ext          = ir[7:4];
  assign imm8         = ir[7:0];
  assign unused_rdest = ir[11:8];
  assign r_info       = alu_lookup(ext);
  assign i_info       = alu_lookup(opc);

  // Classify the instruction and derive ALU operand/strobe attributes
  always_comb begin
    dec     = '0;
    dec.cls = CLS_ILLEGAL;
    if (opc == OPC_RTYPE) begin
      if (r_info.ok) begin
        dec.cls       = CLS_ALU;
        dec.alu_op    = r_info.op;
        dec.alu_b_sel = ALU_B_RF;
        dec.wr        = r_info.wr;
        dec.flags     = r_info.flags;
      end
    end else if (opc == OPC_MEM) begin
      if (ext == EXT_LOAD) begin
        dec.cls = CLS_LOAD;
        dec.wr  = 1'b1;
      end else if (ext == EXT_STOR) begin
        dec.cls = CLS_STORE;
      end
    end else if (i_info.ok) begin
      dec.cls       = CLS_ALU;
      dec.alu_op    = i_info.op;
      dec.alu_b_sel = ALU_B_IMM;
      dec.imm       = i_info.zext ? DATA_WIDTH'(imm8)
                                  : {{(DATA_WIDTH-IMM_W){imm8[IMM_W-1]}}, imm8};
      dec.wr        = i_info.wr;
      dec.flags     = i_info.flags;
    end
    dec.legal = (dec.cls != CLS_ILLEGAL);
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control unit: fetch/decode/execute sequencing and RF/memory strobes.
// Optional macro CTRL_MEM_WAIT_EN: FETCH, MEM_RD and MEM_WR stall until mem_ready.
// Outputs are registered from the next state, so reset clears them immediately.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  mem_addr_sel,
  output logic                  mem_wr_en,
  output logic                  rf_wr_en,
  output logic                  flags_en,
  output logic [REG_BITS-1:0]   rf_addr1,
  output logic [REG_BITS-1:0]   rf_addr2,
  output logic [ALU_OP_W-1:0]   alu_op,
  output logic                  alu_b_sel,
  output logic [DATA_WIDTH-1:0] imm_out,
  output logic                  wb_sel,
  output logic                  illegal
);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  ctrl_out_t             out_q, out_d;
  decode_t               dec;
  logic                  mem_go;
  logic                  fetch_go;

`ifdef CTRL_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  logic unused_mem_ready;
  assign mem_go           = 1'b1;
  assign unused_mem_ready = mem_ready;
`endif

  // Fetch completes only once the FETCH outputs are live (not in the reset-release cycle)
  assign fetch_go = (state_q == FETCH) && out_q.pc_en && mem_go;
  assign ir_d     = fetch_go ? mem_rd_data : ir_q;

  cpu_instr_decode u_decode (
    .ir  (ir_d),
    .dec (dec)
  );

  // State, instruction register and registered output bundle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ir_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      out_q   <= out_d;
    end
  end

  // Next-state sequencing and Moore outputs for the state being entered
  always_comb begin
    state_d = state_q;
    out_d   = '0;

    case (state_q)
      FETCH:   if (fetch_go) state_d = DECODE;
      DECODE: begin
        if (!dec.legal) begin
          state_d = ILLEGAL;
        end else begin
          case (dec.cls)
            CLS_ALU:   state_d = EXEC;
            CLS_LOAD:  state_d = MEM_RD;
            CLS_STORE: state_d = MEM_WR;
            default:   state_d = ILLEGAL;
          endcase
        end
      end
      EXEC:    state_d = FETCH;
      MEM_RD:  if (mem_go) state_d = LOAD_WB;
      LOAD_WB: state_d = FETCH;
      MEM_WR:  if (mem_go) state_d = FETCH;
      ILLEGAL: state_d = ILLEGAL;
      default: state_d = FETCH;
    endcase

    case (state_d)
      FETCH: begin
        out_d.pc_en        = 1'b1;
        out_d.mem_addr_sel = MEM_ADDR_PC;
      end
      DECODE: begin
        out_d.rf_addr1 = ir_d[11:8];
        out_d.rf_addr2 = ir_d[3:0];
      end
      EXEC: begin
        out_d.rf_addr1  = ir_d[11:8];
        out_d.rf_addr2  = ir_d[3:0];
        out_d.alu_op    = dec.alu_op;
        out_d.alu_b_sel = dec.alu_b_sel;
        out_d.imm_out   = dec.imm;
        out_d.rf_wr_en  = dec.wr;
        out_d.flags_en  = dec.flags;
      end
      MEM_RD: begin
        out_d.rf_addr1     = ir_d[11:8];
        out_d.rf_addr2     = ir_d[3:0];
        out_d.mem_addr_sel = MEM_ADDR_RF;
      end
      LOAD_WB: begin
        out_d.rf_addr1 = ir_d[11:8];
        out_d.rf_addr2 = ir_d[3:0];
        out_d.wb_sel   = WB_MEM;
        out_d.rf_wr_en = 1'b1;
      end
      MEM_WR: begin
        out_d.rf_addr1     = ir_d[11:8];
        out_d.rf_addr2     = ir_d[3:0];
        out_d.mem_addr_sel = MEM_ADDR_RF;
        out_d.mem_wr_en    = 1'b1;
      end
      ILLEGAL: out_d.illegal = 1'b1;
      default: out_d = '0;
    endcase
  end

  // pc_en is qualified by memory completion so the PC steps once per fetch
  assign pc_en        = out_q.pc_en & mem_go;
  assign mem_addr_sel = out_q.mem_addr_sel;
  assign mem_wr_en    = out_q.mem_wr_en;
  assign rf_wr_en     = out_q.rf_wr_en;
  assign flags_en     = out_q.flags_en;
  assign rf_addr1     = out_q.rf_addr1;
  assign rf_addr2     = out_q.rf_addr2;
  assign alu_op       = out_q.alu_op;
  assign alu_b_sel    = out_q.alu_b_sel;
  assign imm_out      = out_q.imm_out;
  assign wb_sel       = out_q.wb_sel;
  assign illegal      = out_q.illegal;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: per-cycle expected control vectors from a
// per-instruction reference model, checked by an independent monitor.
module tb_cpu_ctrl_fsm;

  typedef struct packed {
    logic        pc_en;
    logic        addr_sel;
    logic        mem_wr;
    logic        rf_wr;
    logic        flags;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic [2:0]  op;
    logic        bsel;
    logic [15:0] imm;
    logic        wb;
    logic        ill;
  } vec_t;

`ifdef CTRL_MEM_WAIT_EN
  localparam bit WAIT_MODE = 1'b1;
`else
  localparam bit WAIT_MODE = 1'b0;
`endif

  // ALU codes in order ADD, SUB, CMP, AND, OR, XOR, MOV and their alu_op values
  localparam logic [3:0] ALU_CODES [7] = '{4'b0101, 4'b1001, 4'b1011, 4'b0001,
                                           4'b0010, 4'b0011, 4'b1101};
  localparam int         ALU_OPS   [7] = '{0, 1, 1, 2, 3, 4, 5};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mem_rd_data = '0;
  logic        mem_ready = 1'b0;
  logic        pc_en, mem_addr_sel, mem_wr_en, rf_wr_en, flags_en;
  logic [3:0]  rf_addr1, rf_addr2;
  logic [2:0]  alu_op;
  logic        alu_b_sel;
  logic [15:0] imm_out;
  logic        wb_sel, illegal;

  always #5 clk = ~clk;

  cpu_ctrl_fsm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_rd_data  (mem_rd_data),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .mem_addr_sel (mem_addr_sel),
    .mem_wr_en    (mem_wr_en),
    .rf_wr_en     (rf_wr_en),
    .flags_en     (flags_en),
    .rf_addr1     (rf_addr1),
    .rf_addr2     (rf_addr2),
    .alu_op       (alu_op),
    .alu_b_sel    (alu_b_sel),
    .imm_out      (imm_out),
    .wb_sel       (wb_sel),
    .illegal      (illegal)
  );

  vec_t  act;
  assign act = {pc_en, mem_addr_sel, mem_wr_en, rf_wr_en, flags_en, rf_addr1, rf_addr2,
                alu_op, alu_b_sel, imm_out, wb_sel, illegal};

  vec_t  exp_q[$];
  string tag_q[$];
  vec_t  mon_e;
  string mon_tag;
  int    checks = 0;
  int    passed = 0;

  // Monitor: compare the DUT outputs against the next expected cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      checks++;
      if (act === mon_e) passed++;
      else $display("FAIL %s: got %h expected %h", mon_tag, act, mon_e);
      checks++;
      if (!(rf_wr_en === 1'b1 && mem_wr_en === 1'b1)) passed++;
      else $display("FAIL wr_exclusive at %s: rf_wr_en=%b mem_wr_en=%b required not both 1",
                    mon_tag, rf_wr_en, mem_wr_en);
    end
  end

  task automatic push(input vec_t e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Reset pulse asserted mid-cycle: outputs must drop at once and stay low
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; mem_ready = 1'b0;
    push('0, "reset_assert");
    repeat (2) begin
      @(posedge clk); #1;
      push('0, "reset_hold");
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    push('0, "reset_release");
  endtask

  function automatic int alu_index(input logic [3:0] code);
    for (int j = 0; j < 7; j++) if (ALU_CODES[j] == code) return j;
    return -1;
  endfunction

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2: r = {4'h0, r[11:8], ALU_CODES[$urandom_range(0, 6)], r[3:0]};
      3, 4, 5: r = {ALU_CODES[$urandom_range(0, 6)], r[11:0]};
      6:       r = {4'h4, r[11:8], 4'h0, r[3:0]};
      7:       r = {4'h4, r[11:8], 4'h4, r[3:0]};
      default: ;
    endcase
    return r;
  endfunction

  // Reference model: list the control vector of every cycle the instruction occupies
  task automatic run_instr(input logic [15:0] instr, input int abort_pct, input int ill_cycles);
    vec_t        cyc[$];
    bit          memc[$];
    string       tg[$];
    vec_t        v, base;
    logic [3:0]  hi, ext;
    int          k;
    bit          itype, bad, rdy;

    hi  = instr[15:12];
    ext = instr[7:4];
    v = '0; v.pc_en = 1'b1;
    cyc.push_back(v); memc.push_back(1'b1); tg.push_back("fetch");
    base = '0; base.a1 = instr[11:8]; base.a2 = instr[3:0];
    cyc.push_back(base); memc.push_back(1'b0); tg.push_back("decode");

    bad = 1'b0; k = -1; itype = 1'b0;
    if (hi == 4'h0) begin
      k = alu_index(ext);
    end else if (hi == 4'h4) begin
      if (ext == 4'h0) begin
        v = base; v.addr_sel = 1'b1;
        cyc.push_back(v); memc.push_back(1'b1); tg.push_back("load_mem_rd");
        v = base; v.wb = 1'b1; v.rf_wr = 1'b1;
        cyc.push_back(v); memc.push_back(1'b0); tg.push_back("load_wb");
      end else if (ext == 4'h4) begin
        v = base; v.addr_sel = 1'b1; v.mem_wr = 1'b1;
        cyc.push_back(v); memc.push_back(1'b1); tg.push_back("store_mem_wr");
      end else begin
        bad = 1'b1;
      end
    end else begin
      k = alu_index(hi);
      itype = 1'b1;
    end
    if (hi != 4'h4) begin
      if (k < 0) begin
        bad = 1'b1;
      end else begin
        v = base;
        v.op    = 3'(ALU_OPS[k]);
        v.rf_wr = (k != 2);
        v.flags = (k <= 2);
        v.bsel  = itype;
        if (itype) v.imm = (k >= 3 && k <= 5) ? {8'h00, instr[7:0]}
                                              : {{8{instr[7]}}, instr[7:0]};
        cyc.push_back(v); memc.push_back(1'b0); tg.push_back("exec");
      end
    end
    if (bad) begin
      v = '0; v.ill = 1'b1;
      for (int n = 0; n < ill_cycles; n++) begin
        cyc.push_back(v); memc.push_back(1'b0); tg.push_back("illegal_hold");
      end
    end

    foreach (cyc[i]) begin
      if (abort_pct > 0 && $urandom_range(0, 99) < abort_pct) begin
        do_reset();
        return;
      end
      do begin
        @(posedge clk); #1;
        mem_rd_data = (i == 0) ? instr : 16'($urandom);
        rdy = ($urandom_range(0, 3) != 0);
        mem_ready = rdy;
        v = cyc[i];
        if (WAIT_MODE && i == 0) v.pc_en = rdy;
        push(v, tg[i]);
      end while (WAIT_MODE && memc[i] && !rdy);
    end
    if (bad) do_reset();
  endtask

  initial begin
    do_reset();
    run_instr(16'h0553, 0, 0);   // ADD R5, R3
    run_instr(16'hB2FF, 0, 0);   // CMPI R2, -1
    run_instr(16'h4744, 0, 0);   // STOR R7 -> [R4]
    run_instr(16'h4604, 0, 0);   // LOAD R6 <- [R4]
    run_instr(16'h0E70, 0, 20);  // unused ext
    run_instr(16'h1A80, 0, 0);   // ANDI zero-extended immediate
    run_instr(16'h5380, 0, 0);   // ADDI sign-extended immediate
    repeat (400) run_instr(rand_instr(), 3, int'($urandom_range(2, 8)));
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
